// File: rtl/multi_fifo_delay_pkg.sv
// Shared types and sizing helpers for the multi-channel delay line.
package multi_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Index width that stays at least one bit, so a single-channel build still has a legal port.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width able to hold 0..maxlen inclusive (length and fill counters).
    function automatic int len_bits(input int maxlen);
        return $clog2(maxlen) + 1;
    endfunction

    // Requested delays beyond the buffer depth are clamped to the depth.
    function automatic logic [31:0] clamp_len(input logic [31:0] req, input int maxlen);
        return (req > 32'(maxlen)) ? 32'(maxlen) : req;
    endfunction

endpackage

// File: rtl/multi_fifo_delay_if.sv
// Sample, configuration and output bundle of the multi-channel delay line.
interface multi_fifo_delay_if #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 4
);
    import multi_delay_pkg::*;

    localparam int CW = idx_bits(CHANNELS);

    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_ch;
    logic [WIDTH-1:0] in_data;
    logic             cfg_we;
    logic [CW-1:0]    cfg_ch;
    logic [31:0]      cfg_len;
    logic             flush;
    logic             out_valid;
    logic [CW-1:0]    out_ch;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_len, flush,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_len, flush,
        output in_ready, out_valid, out_ch, out_data
    );

endinterface

// File: rtl/multi_fifo_delay_ram.sv
// Simple dual-port synchronous RAM, one-cycle read latency, no reset so it maps to block RAM.
module delay_ram #(
    parameter int WIDTH = 24,
    parameter int AW    = 13
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Registered write and read ports; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/multi_fifo_delay.sv
// Time-multiplexed per-channel delay line: accept -> read old sample -> write new sample.
module multi_fifo_delay
    import multi_delay_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int MAXLEN   = 2048,
    parameter int CHANNELS = 4
) (
    input  logic               clk,
    input  logic               rst,
    multi_fifo_delay_if.slave  bus
);

    localparam int AW  = $clog2(MAXLEN);
    localparam int CW  = idx_bits(CHANNELS);
    localparam int LW  = len_bits(MAXLEN);
    localparam int RAW = CW + AW;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_ch;
    logic [WIDTH-1:0] r_data;
    logic [LW-1:0]    r_lat_len;
    logic [LW-1:0]    r_len  [CHANNELS];
    logic [AW-1:0]    r_wp   [CHANNELS];
    logic [LW-1:0]    r_fill [CHANNELS];
    logic             r_flush_pend;
    logic             r_out_valid;
    logic [CW-1:0]    r_out_ch;
    logic [WIDTH-1:0] r_out_data;

    logic             w_accept;
    logic [LW-1:0]    w_cfg_len;
    logic [LW-1:0]    w_acc_len;
    logic [RAW-1:0]   w_rd_addr;
    logic [RAW-1:0]   w_wr_addr;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_delayed;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_cfg_len = LW'(clamp_len(bus.cfg_len, MAXLEN));
    // A length written in the accept cycle for the same channel wins over the stored one.
    assign w_acc_len = (bus.cfg_we && (bus.cfg_ch == bus.in_ch)) ? w_cfg_len : r_len[bus.in_ch];
    assign w_rd_addr = {r_ch, r_wp[r_ch] - r_lat_len[AW-1:0]};
    assign w_wr_addr = {r_ch, r_wp[r_ch]};

    // Bypass for zero length; unfilled history reads as silence.
    assign w_delayed = (r_lat_len == '0)           ? r_data :
                       (r_fill[r_ch] < r_lat_len)  ? '0     : w_rd_data;

    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;

    delay_ram #(.WIDTH(WIDTH), .AW(RAW)) u_ram (
        .clk       (clk),
        .i_wr_en   (r_state == WRITE),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (r_data),
        .i_rd_en   (r_state == READ),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic and ready.
    always_comb begin
        w_next       = r_state;
        bus.in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = !bus.flush;
                if (w_accept) w_next = READ;
            end
            READ:    w_next = WRITE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Sample latch, per-channel counters, lengths and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch         <= '0;
            r_data       <= '0;
            r_lat_len    <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_data   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_len[i]  <= LW'(1);
                r_wp[i]   <= '0;
                r_fill[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (bus.cfg_we) r_len[bus.cfg_ch] <= w_cfg_len;
            if (w_accept) begin
                r_ch      <= bus.in_ch;
                r_data    <= bus.in_data;
                r_lat_len <= w_acc_len;
            end
            case (r_state)
                IDLE: begin
                    if (bus.flush) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_wp[i]   <= '0;
                            r_fill[i] <= '0;
                        end
                    end
                end
                READ: begin
                    if (bus.flush) r_flush_pend <= 1'b1;
                end
                WRITE: begin
                    r_out_valid <= 1'b1;
                    r_out_ch    <= r_ch;
                    r_out_data  <= w_delayed;
                    // A flush seen mid-sample lets the sample finish, then clears history.
                    if (bus.flush || r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_wp[i]   <= '0;
                            r_fill[i] <= '0;
                        end
                    end else begin
                        r_wp[r_ch] <= r_wp[r_ch] + AW'(1);
                        if (r_fill[r_ch] != LW'(MAXLEN)) r_fill[r_ch] <= r_fill[r_ch] + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multi_fifo_delay.md
MULTI_FIFO_DELAY -- requirements
Module: multi_fifo_delay

Interface
REQ-001 SHALL have parameter WIDTH, default 24: sample width in bits, two's complement.
REQ-002 SHALL have parameter MAXLEN, default 2048: maximum delay in samples per channel; must be a power of two.
REQ-003 SHALL have parameter CHANNELS, default 4: number of independent time-multiplexed delay lines; must be a power of two, at least 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: input sample offered.
REQ-007 SHALL have port in_ready, output, 1: block can accept a sample.
REQ-008 SHALL have port in_ch, input, $clog2(CHANNELS): channel of the offered sample.
REQ-009 SHALL have port in_data, input, WIDTH: offered sample.
REQ-010 SHALL have port cfg_we, input, 1: length write strobe.
REQ-011 SHALL have port cfg_ch, input, $clog2(CHANNELS): channel whose length is written.
REQ-012 SHALL have port cfg_len, input, 32: requested delay in samples.
REQ-013 SHALL have port flush, input, 1: synchronous clear of all delay history.
REQ-014 SHALL have port out_valid, output, 1: one-cycle pulse marking a delayed sample.
REQ-015 SHALL have port out_ch, output, $clog2(CHANNELS): channel of out_data.
REQ-016 SHALL have port out_data, output, WIDTH: delayed sample, held until the next out_valid.

Function
REQ-017 SHALL run an FSM with states IDLE, READ and WRITE; in_ready SHALL be 1 only in IDLE with flush low.
REQ-018 SHALL accept a sample on a cycle with in_valid and in_ready both high, latch in_ch and in_data, and go IDLE->READ.
REQ-019 READ SHALL issue the RAM read at address {ch, wp[ch] - len[ch]} (mod MAXLEN) and go to WRITE.
REQ-020 WRITE SHALL write the latched sample at {ch, wp[ch]}, increment wp[ch] mod MAXLEN, saturate-increment fill[ch] at MAXLEN, drive out_valid=1 with out_ch and out_data, and return to IDLE.
REQ-021 Latency SHALL be 2 cycles (accept edge to the out_valid cycle); throughput SHALL be one sample per 3 cycles.
REQ-022 out_data SHALL equal the sample accepted len[ch] accepts earlier on the same channel; it SHALL be 0 while fill[ch] < len[ch].
REQ-023 len[ch]=0 SHALL bypass: out_data equals the current sample.
REQ-024 cfg_len > MAXLEN SHALL be clamped to MAXLEN; len=MAXLEN SHALL return the sample overwritten by the current write (read-before-write).
REQ-025 Accepts on one channel SHALL never alter wp, fill or the RAM region of another channel.
REQ-026 cfg_we SHALL update len[cfg_ch] immediately; a sample already past IDLE SHALL use the latched old length; RAM contents and fill SHALL be preserved.
REQ-027 flush SHALL zero all wp and fill counters on the next edge; a flush during READ/WRITE SHALL let that sample complete first, then apply the clear.
REQ-028 Simultaneous cfg_we and accept on the same channel SHALL give the accepted sample the new length.

Reset
REQ-029 On rst: state=IDLE, out_valid=0, out_ch=0, out_data=0, all wp=0, all fill=0, all len=1.
REQ-030 rst during READ or WRITE SHALL abort the sample with no out_valid; RAM contents need not be cleared, since fill masks them.

Structure
REQ-031 Package multi_delay_pkg SHALL hold the state enum and helper functions for the address-width constants.
REQ-032 SHALL instantiate one sub-module, delay_ram: simple dual-port synchronous RAM of CHANNELS*MAXLEN x WIDTH with 1-cycle read latency and no reset, so it infers BRAM.

Verification
REQ-033 len[0]=3; accept 10,20,30,40,50 on ch0 -> out 0,0,0,10,20, each out_valid 2 cycles after its accept.
REQ-034 Interleave ch0 (len 2) and ch1 (len 1) with ch0=1,2,3 and ch1=7,8,9 -> ch0 out 0,0,1; ch1 out 0,7,8.
REQ-035 len=0 on ch2; accept 5 -> out 5; cfg_len=5000 -> stored length 2048 (MAXLEN).
REQ-036 len=MAXLEN; accept MAXLEN+1 ramp samples 1..2049 -> first MAXLEN outputs 0, last output 1.
REQ-037 len=2; accept 1,2,3; flush; accept 4 -> out 0; assert rst in READ -> no out_valid, in_ready=1 after release.
